// File: rtl/pbs_pkg.sv
// Shared types and constants for the push-button / move-switch input path.
//   key_state_t           : debounce FSM states
//   MOVE_W_DEFAULT        : default width of the player move code
//   DEBOUNCE_CYCLES_50MHZ : 20 ms of stable level at 50 MHz
package pbs_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  localparam int unsigned MOVE_W_DEFAULT        = 2;
  localparam int unsigned DEBOUNCE_CYCLES_50MHZ = 1000000;

endpackage

// File: rtl/pbs_sync2.sv
// Two-flop synchroniser for asynchronous level inputs.
//   clk, reset_n : clock, async active-low reset (both flops load RESET_VAL)
//   d_i          : asynchronous input
//   q_o          : synchronised output, two clocks of latency
module pbs_sync2 #(
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pbs_key_capture.sv
// Conditions the raw push-button and move switches for the battle control FSM.
//   clk, reset_n : clock, async active-low reset
//   key_n        : raw button, 0 = pressed, asynchronous
//   move_sw      : raw move switches, asynchronous
//   enable       : control FSM is accepting moves
//   move_ack     : control FSM consumed the held move
//   go_pulse     : one-cycle pulse per debounced press
//   key_level    : debounced level, 1 = pressed
//   move         : move latched on the last accepted press
//   move_valid   : move holds an unconsumed value
//   overrun      : one-cycle pulse when a press could not deliver its move
module pbs_key_capture
  import pbs_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
  parameter int unsigned MOVE_W          = MOVE_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              key_n,
  input  logic [MOVE_W-1:0] move_sw,
  input  logic              enable,
  input  logic              move_ack,
  output logic              go_pulse,
  output logic              key_level,
  output logic [MOVE_W-1:0] move,
  output logic              move_valid,
  output logic              overrun
);

  localparam int unsigned    CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic              key_sync;
  logic [MOVE_W-1:0] move_sync;

  key_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              press_evt_c;
  logic              press_evt_q;
  logic              accept_c;

  logic              go_pulse_q;
  logic              key_level_q, key_level_d;
  logic [MOVE_W-1:0] move_q, move_d;
  logic              move_valid_q, move_valid_d;
  logic              overrun_q, overrun_d;

  // Released key reads 1 out of reset so a held key is seen as a fresh press.
  pbs_sync2 #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync_key (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (key_n),
    .q_o     (key_sync)
  );

  pbs_sync2 #(
    .WIDTH     (MOVE_W),
    .RESET_VAL ('0)
  ) u_sync_move (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (move_sw),
    .q_o     (move_sync)
  );

  // Debounce FSM: a level change must hold for DEBOUNCE_CYCLES before acceptance.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_evt_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!key_sync) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (key_sync) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = PRESSED;
          press_evt_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (key_sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!key_sync) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Move handshake; acts on the press event registered one cycle after PRESSED entry.
  always_comb begin
    move_d       = move_q;
    move_valid_d = move_valid_q;
    accept_c     = enable && (!move_valid_q || move_ack);
    overrun_d    = press_evt_q && !accept_c;
    key_level_d  = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    if (press_evt_q && accept_c) begin
      move_d       = move_sync;
      move_valid_d = 1'b1;
    end else if (move_ack && move_valid_q) begin
      move_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      press_evt_q  <= 1'b0;
      go_pulse_q   <= 1'b0;
      key_level_q  <= 1'b0;
      move_q       <= '0;
      move_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      press_evt_q  <= press_evt_c;
      go_pulse_q   <= press_evt_q;
      key_level_q  <= key_level_d;
      move_q       <= move_d;
      move_valid_q <= move_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign go_pulse   = go_pulse_q;
  assign key_level  = key_level_q;
  assign move       = move_q;
  assign move_valid = move_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_pbs_key_capture.sv
// Bench for pbs_key_capture: directed scenarios plus randomized key/switch traffic,
// checked against a run-length reference model and an event scoreboard.
module tb_pbs_key_capture;

  localparam int unsigned D  = 4;
  localparam int unsigned MW = 2;

  logic          clk;
  logic          reset_n;
  logic          key_n;
  logic [MW-1:0] move_sw;
  logic          enable;
  logic          move_ack;
  logic          go_pulse;
  logic          key_level;
  logic [MW-1:0] move;
  logic          move_valid;
  logic          overrun;

  pbs_key_capture #(
    .DEBOUNCE_CYCLES (D),
    .MOVE_W          (MW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_n      (key_n),
    .move_sw    (move_sw),
    .enable     (enable),
    .move_ack   (move_ack),
    .go_pulse   (go_pulse),
    .key_level  (key_level),
    .move       (move),
    .move_valid (move_valid),
    .overrun    (overrun)
  );

  typedef struct packed {
    logic [MW-1:0] mv;
    logic          vld;
    logic          ov;
  } ev_t;

  ev_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: raw samples delayed two clocks, debounced level,
  // length of the current run of samples disagreeing with that level.
  logic          m_k1 = 1'b1, m_k2 = 1'b1;
  logic [MW-1:0] m_s1 = '0, m_s2 = '0;
  logic          m_lvl = 1'b0;
  int            m_run = 0;
  logic          m_pend = 1'b0;
  logic          e_go = 1'b0, e_ov = 1'b0, e_vld = 1'b0;
  logic [MW-1:0] e_mv = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A press is recognised once D+1 consecutive synchronised samples disagree
  // with the debounced level; go/move capture follow one clock later.
  task automatic model_step();
    if (!reset_n) begin
      m_k1 = 1'b1; m_k2 = 1'b1; m_s1 = '0; m_s2 = '0;
      m_lvl = 1'b0; m_run = 0; m_pend = 1'b0;
      e_go = 1'b0; e_ov = 1'b0; e_vld = 1'b0; e_mv = '0;
      sb.delete();
    end else begin
      e_go = m_pend;
      e_ov = 1'b0;
      if (m_pend && enable && (!e_vld || move_ack)) begin
        e_mv  = m_s2;
        e_vld = 1'b1;
      end else begin
        if (m_pend) e_ov = 1'b1;
        if (move_ack && e_vld) e_vld = 1'b0;
      end
      if (m_pend) sb.push_back('{mv: e_mv, vld: e_vld, ov: e_ov});
      m_pend = 1'b0;
      if ((!m_k2) == m_lvl) begin
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == int'(D) + 1) begin
          m_lvl  = !m_lvl;
          m_run  = 0;
          m_pend = m_lvl;
        end
      end
      m_k2 = m_k1; m_k1 = key_n;
      m_s2 = m_s1; m_s1 = move_sw;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      model_step();
    end
  end

  // Monitor: per-cycle output check, and event payload popped on every go pulse.
  initial begin
    ev_t rec;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        chk("go_pulse",   32'(go_pulse),   32'(e_go));
        chk("key_level",  32'(key_level),  32'(m_lvl));
        chk("move",       32'(move),       32'(e_mv));
        chk("move_valid", 32'(move_valid), 32'(e_vld));
        chk("overrun",    32'(overrun),    32'(e_ov));
        if (go_pulse) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL go_unexpected: got go_pulse=1 required no pending event at %0t", $time);
          end else begin
            rec = sb.pop_front();
            chk("ev_move",    32'(move),       32'(rec.mv));
            chk("ev_valid",   32'(move_valid), 32'(rec.vld));
            chk("ev_overrun", 32'(overrun),    32'(rec.ov));
          end
        end
      end
    end
  end

  // Watch edges 0..13 after the key is low; report the first go edge and its payload.
  task automatic watch(input bit ack_at_go, output int ge, output int gc,
                       output logic ov, output logic [MW-1:0] mv, output logic vld);
    ge = -1; gc = 0; ov = 1'b0; mv = '0; vld = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      if (go_pulse) begin
        gc++;
        if (ge < 0) begin
          ge = i; ov = overrun; mv = move; vld = move_valid;
        end
      end
      @(negedge clk);
      if (ack_at_go) move_ack = (i == 6);
    end
  endtask

  task automatic press(input logic [MW-1:0] sw, input bit ack_at_go, output int ge, output int gc,
                       output logic ov, output logic [MW-1:0] mv, output logic vld);
    @(negedge clk);
    key_n   = 1'b0;
    move_sw = sw;
    watch(ack_at_go, ge, gc, ov, mv, vld);
  endtask

  task automatic release_key();
    @(negedge clk);
    key_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    move_ack = 1'b1;
    @(negedge clk);
    move_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int            ge, gc, run_left;
    logic          ov, vld, any_go, any_lvl, any_vld;
    logic [MW-1:0] mv;

    reset_n = 1'b0; key_n = 1'b1; move_sw = '0; enable = 1'b1; move_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_go",    32'(go_pulse),   32'd0);
    chk("rst_level", 32'(key_level),  32'd0);
    chk("rst_move",  32'(move),       32'd0);
    chk("rst_valid", 32'(move_valid), 32'd0);
    chk("rst_ovr",   32'(overrun),    32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean press
    press(2'b10, 1'b0, ge, gc, ov, mv, vld);
    chk("clean_latency", 32'(ge), 32'd7);
    chk("clean_count",   32'(gc), 32'd1);
    chk("clean_ovr",     32'(ov), 32'd0);
    chk("clean_move",    32'(mv), 32'(2'b10));
    chk("clean_valid",   32'(vld), 32'd1);
    chk("clean_level",   32'(key_level), 32'd1);
    release_key();
    chk("release_level", 32'(key_level), 32'd0);
    ack_pulse();
    chk("ack1_valid", 32'(move_valid), 32'd0);
    chk("ack1_move",  32'(move), 32'(2'b10));

    // Bounce rejection
    any_go = 1'b0; any_lvl = 1'b0; any_vld = 1'b0;
    for (int r = 0; r < 3; r++) begin
      key_n = 1'b0;
      repeat (3) begin
        @(negedge clk);
        any_go |= go_pulse; any_lvl |= key_level; any_vld |= move_valid;
      end
      key_n = 1'b1;
      @(negedge clk);
      any_go |= go_pulse; any_lvl |= key_level; any_vld |= move_valid;
    end
    repeat (10) begin
      @(negedge clk);
      any_go |= go_pulse; any_lvl |= key_level; any_vld |= move_valid;
    end
    chk("bounce_go",    32'(any_go),  32'd0);
    chk("bounce_level", 32'(any_lvl), 32'd0);
    chk("bounce_valid", 32'(any_vld), 32'd0);

    // Handshake
    press(2'b01, 1'b0, ge, gc, ov, mv, vld);
    chk("hs1_move", 32'(mv), 32'(2'b01));
    chk("hs1_valid", 32'(vld), 32'd1);
    release_key();
    ack_pulse();
    chk("hs_ack_valid", 32'(move_valid), 32'd0);
    chk("hs_ack_move",  32'(move), 32'(2'b01));
    press(2'b11, 1'b0, ge, gc, ov, mv, vld);
    chk("hs2_move", 32'(mv), 32'(2'b11));
    chk("hs2_valid", 32'(vld), 32'd1);
    release_key();

    // Overrun: held move not consumed
    press(2'b00, 1'b0, ge, gc, ov, mv, vld);
    chk("ovr_latency", 32'(ge), 32'd7);
    chk("ovr_flag",    32'(ov), 32'd1);
    chk("ovr_move",    32'(mv), 32'(2'b11));
    chk("ovr_valid",   32'(vld), 32'd1);
    @(negedge clk);
    chk("ovr_one_cycle", 32'(overrun), 32'd0);
    release_key();
    ack_pulse();

    // Disabled
    enable = 1'b0;
    press(2'b10, 1'b0, ge, gc, ov, mv, vld);
    chk("dis_latency", 32'(ge), 32'd7);
    chk("dis_flag",    32'(ov), 32'd1);
    chk("dis_valid",   32'(vld), 32'd0);
    release_key();
    enable = 1'b1;

    // Ack coinciding with the press
    press(2'b01, 1'b0, ge, gc, ov, mv, vld);
    release_key();
    press(2'b00, 1'b1, ge, gc, ov, mv, vld);
    chk("sim_valid", 32'(vld), 32'd1);
    chk("sim_move",  32'(mv), 32'(2'b00));
    chk("sim_ovr",   32'(ov), 32'd0);
    release_key();

    // Async reset during PRESS_WAIT, key kept held
    @(negedge clk);
    key_n = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_go",    32'(go_pulse),   32'd0);
    chk("arst_level", 32'(key_level),  32'd0);
    chk("arst_move",  32'(move),       32'd0);
    chk("arst_valid", 32'(move_valid), 32'd0);
    chk("arst_ovr",   32'(overrun),    32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    watch(1'b0, ge, gc, ov, mv, vld);
    chk("arst_latency", 32'(ge), 32'd7);
    chk("arst_count",   32'(gc), 32'd1);
    release_key();

    // Randomized traffic; runs straddle the D+1 sample threshold
    run_left = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (run_left == 0) begin
        key_n    = ~key_n;
        run_left = int'($urandom_range(1, 12));
      end
      run_left--;
      move_sw  = MW'($urandom);
      enable   = ($urandom_range(0, 7) != 0);
      move_ack = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    move_ack = 1'b0;
    key_n    = 1'b1;
    repeat (20) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
